// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default sizes for the round-robin memory arbiter.
// The timeout abort path in the top level is enabled with MEM_ARB_TIMEOUT_EN.
package mem_arb_pkg;

  // Arbiter FSM: IDLE arbitrates, BUSY owns the memory for one transfer.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Default geometry of the shared single-port memory.
  localparam int DEF_WIDTH      = 16;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_ADDR_WIDTH = $clog2(DEF_DEPTH);

  // Transfer direction encoding on wr_rd lines.
  localparam logic WR = 1'b1;
  localparam logic RD = 1'b0;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// mem_arb_rr_pick: combinational rotate-priority encoder.
// Searches req starting at ptr, wrapping modulo N, and returns the first
// set position both as a one-hot vector and as a binary index.
module mem_arb_rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);

  logic [PW:0] pos;
  logic        found;

  // Walk the requesters in priority order ptr, ptr+1, ... and latch the first hit.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, ptr} + (PW+1)'(i);
      if (pos >= (PW+1)'(N)) begin
        pos = pos - (PW+1)'(N);
      end
      if (!found && req[pos[PW-1:0]]) begin
        gnt[pos[PW-1:0]] = 1'b1;
        gnt_idx          = pos[PW-1:0];
        found            = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin arbiter sharing one single-port memory among
// N_REQ requesters, one transfer in flight at a time.
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort a transfer after
// TIMEOUT_CYC busy cycles without mem_ready_i (reported via req_err_o).
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = DEF_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [N_REQ-1:0]          req_wr_rd_i,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [N_REQ*WIDTH-1:0]    req_wr_data_i,
  output logic [N_REQ-1:0]          req_ready_o,
  output logic [N_REQ-1:0]          req_err_o,
  output logic [WIDTH-1:0]          rd_data_o,
  output logic [N_REQ-1:0]          gnt_o,
  output logic                      mem_valid_o,
  output logic                      mem_wr_rd_o,
  output logic [ADDR_WIDTH-1:0]     mem_addr_o,
  output logic [WIDTH-1:0]          mem_wr_data_o,
  input  logic                      mem_ready_i,
  input  logic [WIDTH-1:0]          mem_rd_data_i
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [PW-1:0]    idx_q, idx_d;
  logic [PW-1:0]    ptr_q, ptr_d;

  logic [N_REQ-1:0] pick_gnt;
  logic [PW-1:0]    pick_idx;
  logic             pick_any;

  logic             busy;
  logic             done;
  logic             expire;
  logic             finish;

  mem_arb_rr_pick #(
    .N  (N_REQ),
    .PW (PW)
  ) u_pick (
    .req     (req_valid_i),
    .ptr     (ptr_q),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  assign busy   = (state_q == BUSY);
  assign done   = busy & mem_ready_i;
  assign finish = done | expire;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Expiry fires only when ready is absent, so a late ready still completes normally.
  assign expire    = busy & ~mem_ready_i & (cnt_q == CW'(TIMEOUT_CYC - 1));
  assign req_err_o = expire ? gnt_q : '0;

  // Busy-cycle counter: held at zero while idle so each transfer starts from 0.
  always_comb begin
    cnt_d = cnt_q;
    if (!busy) begin
      cnt_d = '0;
    end else if (!finish) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign expire    = 1'b0;
  assign req_err_o = '0;
`endif

  // Next-state logic: arbitrate in IDLE, release grant and advance pointer on completion.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = BUSY;
          gnt_d   = pick_gnt;
          idx_d   = pick_idx;
        end
      end
      BUSY: begin
        if (finish) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = (idx_q == PW'(N_REQ - 1)) ? '0 : idx_q + PW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  // Memory request mux: AND-OR select by the one-hot grant, all zero while idle.
  always_comb begin
    mem_wr_rd_o   = 1'b0;
    mem_addr_o    = '0;
    mem_wr_data_o = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_q[k]) begin
        mem_wr_rd_o   = req_wr_rd_i[k];
        mem_addr_o    = req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        mem_wr_data_o = req_wr_data_i[k*WIDTH +: WIDTH];
      end
    end
  end

  assign mem_valid_o = busy;
  assign gnt_o       = gnt_q;
  assign req_ready_o = finish ? gnt_q : '0;
  assign rd_data_o   = done ? mem_rd_data_i : '0;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter: directed and randomized checks of mem_rr_arbiter against
// a transaction-level reference model with a bench-side memory image.
module tb_mem_rr_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int AW = 4;
  localparam int TO = 64;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [N-1:0]    req_valid_i;
  logic [N-1:0]    req_wr_rd_i;
  logic [N*AW-1:0] req_addr_i;
  logic [N*W-1:0]  req_wr_data_i;
  logic [N-1:0]    req_ready_o;
  logic [N-1:0]    req_err_o;
  logic [W-1:0]    rd_data_o;
  logic [N-1:0]    gnt_o;
  logic            mem_valid_o;
  logic            mem_wr_rd_o;
  logic [AW-1:0]   mem_addr_o;
  logic [W-1:0]    mem_wr_data_o;
  logic            mem_ready_i;
  logic [W-1:0]    mem_rd_data_i;

  int total = 0;
  int bad   = 0;

  // Reference model: granted requester (-1 idle), pointer, busy cycles.
  int          m_gnt  = -1;
  int          m_ptr  = 0;
  int          m_busy = 0;
  int          gnt_log[$];
  logic [N-1:0] done_evt;
  logic [W-1:0] store [16];

  logic         e_busy, e_done, e_exp;
  logic [N-1:0] e_gnt, e_ready, e_err;
  logic [W-1:0] e_rd, e_wdata;
  logic [AW-1:0] e_addr;
  logic         e_wr;

  logic [N-1:0] seen_gnt [10];
  logic [N-1:0] seen_rdy [10];
  logic [N-1:0] pending;
  logic [N-1:0] want;

  always #5 clk_i = ~clk_i;

  mem_rr_arbiter #(
    .N_REQ       (N),
    .WIDTH       (W),
    .ADDR_WIDTH  (AW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_valid_i   (req_valid_i),
    .req_wr_rd_i   (req_wr_rd_i),
    .req_addr_i    (req_addr_i),
    .req_wr_data_i (req_wr_data_i),
    .req_ready_o   (req_ready_o),
    .req_err_o     (req_err_o),
    .rd_data_o     (rd_data_o),
    .gnt_o         (gnt_o),
    .mem_valid_o   (mem_valid_o),
    .mem_wr_rd_o   (mem_wr_rd_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wr_data_o (mem_wr_data_o),
    .mem_ready_i   (mem_ready_i),
    .mem_rd_data_i (mem_rd_data_i)
  );

  // One comparison: counts it and reports a mismatch.
  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round-robin choice from the rule: first valid in order ptr, ptr+1, ... mod N.
  function automatic int rr_choose(input logic [N-1:0] v, input int ptr);
    for (int o = 0; o < N; o++) begin
      if (v[(ptr + o) % N]) return (ptr + o) % N;
    end
    return -1;
  endfunction

  // Requester k raises a request with the given direction, address and data.
  task automatic apply_stimulus(input int k, input logic wr, input logic [AW-1:0] a, input logic [W-1:0] d);
    req_valid_i[k]           = 1'b1;
    req_wr_rd_i[k]           = wr;
    req_addr_i[k*AW +: AW]   = a;
    req_wr_data_i[k*W +: W]  = d;
  endtask

  task automatic drop_req(input int k);
    req_valid_i[k] = 1'b0;
  endtask

  // Memory side: return the bench memory image for the address being served.
  task automatic drive_mem();
    if (m_gnt >= 0) mem_rd_data_i = store[req_addr_i[m_gnt*AW +: AW]];
    else            mem_rd_data_i = W'($urandom);
  endtask

  // Advance to just after the next rising edge and refresh the memory response.
  task automatic step();
    @(posedge clk_i);
    #1;
    drive_mem();
  endtask

  function automatic logic [63:0] all_outputs();
    return {14'b0, gnt_o, req_ready_o, req_err_o, mem_valid_o, mem_wr_rd_o, mem_addr_o, rd_data_o, mem_wr_data_o};
  endfunction

  // Per-cycle compare against the model, then advance the model across the coming edge.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      check_output("reset_outputs", all_outputs(), 64'h0);
      m_gnt  = -1;
      m_ptr  = 0;
      m_busy = 0;
    end else begin
      e_busy = (m_gnt >= 0);
      e_gnt  = '0;
      if (e_busy) e_gnt[m_gnt] = 1'b1;
      e_done = e_busy && mem_ready_i;
      e_exp  = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      e_exp  = e_busy && !mem_ready_i && (m_busy == TO - 1);
`endif
      e_ready = (e_done || e_exp) ? e_gnt : '0;
      e_err   = e_exp ? e_gnt : '0;
      e_rd    = e_done ? mem_rd_data_i : '0;
      e_wr    = 1'b0;
      e_addr  = '0;
      e_wdata = '0;
      if (e_busy) begin
        e_wr    = req_wr_rd_i[m_gnt];
        e_addr  = req_addr_i[m_gnt*AW +: AW];
        e_wdata = req_wr_data_i[m_gnt*W +: W];
        assert (req_valid_i[m_gnt])
          else $error("[TB] protocol: requester %0d dropped valid while granted", m_gnt);
      end
      check_output("gnt_o",         gnt_o,         e_gnt);
      check_output("mem_valid_o",   mem_valid_o,   e_busy);
      check_output("mem_wr_rd_o",   mem_wr_rd_o,   e_wr);
      check_output("mem_addr_o",    mem_addr_o,    e_addr);
      check_output("mem_wr_data_o", mem_wr_data_o, e_wdata);
      check_output("req_ready_o",   req_ready_o,   e_ready);
      check_output("req_err_o",     req_err_o,     e_err);
      check_output("rd_data_o",     rd_data_o,     e_rd);
      if (e_done && !e_wr) check_output("sb_read", rd_data_o, store[e_addr]);
      if (e_done && e_wr)  store[e_addr] = e_wdata;
      if (e_busy) begin
        if (e_done || e_exp) begin
          done_evt[m_gnt] = 1'b1;
          m_ptr  = (m_gnt + 1) % N;
          m_gnt  = -1;
        end else begin
          m_busy++;
        end
      end else begin
        m_gnt  = rr_choose(req_valid_i, m_ptr);
        m_busy = 0;
        if (m_gnt >= 0) gnt_log.push_back(m_gnt);
      end
    end
  end

  initial begin
    req_valid_i   = '0;
    req_wr_rd_i   = '0;
    req_addr_i    = '0;
    req_wr_data_i = '0;
    mem_ready_i   = 1'b0;
    mem_rd_data_i = '0;
    done_evt      = '0;
    pending       = '0;
    want          = '0;
    for (int i = 0; i < 16; i++) store[i] = '0;
    rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check_output("reset_idle", all_outputs(), 64'h0);
    rst_i = 1'b1;

    // Single write from requester 0.
    apply_stimulus(0, 1'b1, 4'd3, 16'hA5A5);
    mem_ready_i = 1'b1;
    step(); #2;
    check_output("wr_mem_addr",  mem_addr_o,    4'd3);
    check_output("wr_mem_data",  mem_wr_data_o, 16'hA5A5);
    check_output("wr_mem_dir",   mem_wr_rd_o,   1'b1);
    check_output("wr_ready",     req_ready_o,   4'b0001);
    step(); drop_req(0); #2;
    check_output("wr_after_ready", req_ready_o, 4'b0000);
    check_output("wr_after_gnt",   gnt_o,       4'b0000);

    // Read from requester 2, memory returns 16'h1234.
    store[7] = 16'h1234;
    apply_stimulus(2, 1'b0, 4'd7, 16'h0);
    step(); #2;
    check_output("rd_data",  rd_data_o,   16'h1234);
    check_output("rd_ready", req_ready_o, 4'b0100);
    check_output("rd_addr",  mem_addr_o,  4'd7);
    step(); drop_req(2); #2;
    check_output("rd_idle_data", rd_data_o, 16'h0);

    // Fairness: all four valid continuously from reset.
    rst_i = 1'b0;
    step(); step();
    gnt_log.delete();
    for (int k = 0; k < N; k++) apply_stimulus(k, 1'b0, AW'(k), 16'h0);
    rst_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step(); #2;
      seen_gnt[c] = gnt_o;
      seen_rdy[c] = req_ready_o;
    end
    req_valid_i = '0;
    for (int c = 0; c < 10; c++) begin
      check_output($sformatf("fair_gnt_%0d", c), seen_gnt[c], (c % 2 == 0) ? (4'b0001 << ((c / 2) % 4)) : 4'b0000);
      check_output($sformatf("fair_rdy_%0d", c), seen_rdy[c], (c % 2 == 0) ? (4'b0001 << ((c / 2) % 4)) : 4'b0000);
    end
    check_output("fair_log_len", gnt_log.size(), 5);
    if (gnt_log.size() == 5) begin
      check_output("fair_log_0", gnt_log[0], 0);
      check_output("fair_log_1", gnt_log[1], 1);
      check_output("fair_log_2", gnt_log[2], 2);
      check_output("fair_log_3", gnt_log[3], 3);
      check_output("fair_log_4", gnt_log[4], 0);
    end

    // Pointer: after serving requester 1, requests on 0 and 3 go 3 first.
    step();
    apply_stimulus(1, 1'b1, 4'd1, 16'h1111);
    step(); #2;
    check_output("ptr_gnt1", gnt_o, 4'b0010);
    step(); drop_req(1);
    apply_stimulus(0, 1'b1, 4'd4, 16'h4444);
    apply_stimulus(3, 1'b1, 4'd5, 16'h5555);
    step(); #2;
    check_output("ptr_gnt3", gnt_o, 4'b1000);
    step(); drop_req(3);
    step(); #2;
    check_output("ptr_gnt0", gnt_o, 4'b0001);
    step(); drop_req(0);

    // Back-pressure: ready held low five busy cycles.
    apply_stimulus(1, 1'b1, 4'd9, 16'hBEEF);
    mem_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(); #2;
      check_output($sformatf("bp_valid_%0d", i), mem_valid_o, 1'b1);
      check_output($sformatf("bp_addr_%0d", i),  mem_addr_o,  4'd9);
      check_output($sformatf("bp_ready_%0d", i), req_ready_o, 4'b0000);
    end
    step(); mem_ready_i = 1'b1; #2;
    check_output("bp_ready_6th", req_ready_o, 4'b0010);
    step(); drop_req(1);

    // Reset mid-transfer clears everything and restarts the pointer at 0.
    apply_stimulus(3, 1'b0, 4'd5, 16'h0);
    mem_ready_i = 1'b0;
    step(); #1;
    check_output("rst_pre_gnt", gnt_o, 4'b1000);
    #1 rst_i = 1'b0;
    #1;
    check_output("rst_async_outputs", all_outputs(), 64'h0);
    drop_req(3);
    step(); step();
    apply_stimulus(0, 1'b0, 4'd2, 16'h0);
    apply_stimulus(3, 1'b0, 4'd5, 16'h0);
    mem_ready_i = 1'b1;
    rst_i = 1'b1;
    step(); #2;
    check_output("rst_ptr_gnt0", gnt_o, 4'b0001);
    step(); drop_req(0); drop_req(3);
    check_output("model_ptr", m_ptr, 1);

`ifdef MEM_ARB_TIMEOUT_EN
    // Timeout: memory never answers; abort pulse on busy cycle 64.
    apply_stimulus(2, 1'b0, 4'd1, 16'h0);
    mem_ready_i = 1'b0;
    repeat (TO - 1) step();
    step(); #2;
    check_output("to_err",   req_err_o,   4'b0100);
    check_output("to_ready", req_ready_o, 4'b0100);
    step(); drop_req(2); #2;
    check_output("to_valid_drop", mem_valid_o, 1'b0);
`endif

    // Randomized traffic with protocol-obeying requesters.
    step();
    done_evt = '0;
    pending  = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      mem_ready_i = ($urandom_range(0, 3) != 0);
      want = done_evt;
      done_evt = '0;
      for (int k = 0; k < N; k++) begin
        if (want[k]) begin
          pending[k] = 1'b0;
          drop_req(k);
        end
        if (!pending[k] && ($urandom_range(0, 2) == 0)) begin
          pending[k] = 1'b1;
          apply_stimulus(k, 1'($urandom), AW'($urandom), W'($urandom));
        end
      end
    end
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
